jk_seq_driver: RTL

- Command-driven sequencer that sits directly upstream of a bank of WIDTH jkflipflop instances.
- Drives each flip-flop's j/k inputs so that the bank's q vector follows a requested operation (hold, load, count up/down, toggle mask) for a requested number of cycles.
- Reads the bank's q back as feedback.
- Turns the single-bit JK storage cell into a controllable register/counter.

---
 rtl/jk_seq_pkg.sv | 22 ++
 rtl/jk_excite.sv | 16 +
 rtl/jk_seq_driver.sv | 138 +++++++++++++
 3 files changed

// File: rtl/jk_seq_pkg.sv
// Shared definitions for the JK flip-flop bank sequencer: command opcodes,
// FSM states and the opcode normalisation helper.
package jk_seq_pkg;

    localparam logic [2:0] OP_HOLD   = 3'd0;
    localparam logic [2:0] OP_LOAD   = 3'd1;
    localparam logic [2:0] OP_UP     = 3'd2;
    localparam logic [2:0] OP_DN     = 3'd3;
    localparam logic [2:0] OP_TOGGLE = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Unassigned opcodes (5-7) collapse onto HOLD so the datapath only sees legal values.
    function automatic logic [2:0] norm_op(input logic [2:0] op);
        return (op > OP_TOGGLE) ? OP_HOLD : op;
    endfunction

endpackage

// File: rtl/jk_excite.sv
// Per-bit JK excitation: returns the j/k pair that moves each flip-flop from
// its present value q to the requested target on the next clock edge.
module jk_excite #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] target,
    input  logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k
);

    // Set only bits that must rise, reset only bits that must fall; equal bits hold.
    assign j = target & ~q;
    assign k = ~target & q;

endmodule

// File: rtl/jk_seq_driver.sv
// Command sequencer driving the j/k inputs of a WIDTH-bit JK flip-flop bank.
// Optional feedback checker enabled by defining JK_SEQ_CHECK_EN.
module jk_seq_driver
    import jk_seq_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic [WIDTH-1:0] q_fb,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k,
    output logic             busy,
    output logic             done,
    output logic             err
);

    state_t           state_q, state_d;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] data_q;
    logic [LEN_W-1:0] rem_q;
    logic [WIDTH-1:0] target;
    logic [WIDTH-1:0] j_ex, k_ex;
    logic             accept;
    logic             cmd_is_load;
    logic             in_run;

    assign accept      = cmd_valid && (state_q == ST_IDLE);
    assign cmd_is_load = (norm_op(cmd_op) == OP_LOAD);
    assign in_run      = (state_q == ST_RUN);

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: state_d gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    if (!cmd_is_load && (cmd_len == '0)) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (rem_q == LEN_W'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q   <= OP_HOLD;
            data_q <= '0;
            rem_q  <= '0;
        end else if (accept) begin
            op_q   <= norm_op(cmd_op);
            data_q <= cmd_data;
            rem_q  <= cmd_is_load ? LEN_W'(1) : cmd_len;
        end else if (in_run) begin
            rem_q  <= rem_q - LEN_W'(1);
        end
    end

    // Target is formed straight from q_fb: the bank itself is the state register.
    always_comb begin
        target = q_fb;
        case (op_q)
            OP_LOAD:   target = data_q;
            OP_UP:     target = q_fb + WIDTH'(1);
            OP_DN:     target = q_fb - WIDTH'(1);
            OP_TOGGLE: target = q_fb ^ data_q;
            default:   target = q_fb;
        endcase
    end

    jk_excite #(
        .WIDTH (WIDTH)
    ) u_excite (
        .target (target),
        .q      (q_fb),
        .j      (j_ex),
        .k      (k_ex)
    );

    assign j         = in_run ? j_ex : '0;
    assign k         = in_run ? k_ex : '0;
    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);

`ifdef JK_SEQ_CHECK_EN
    logic [WIDTH-1:0] exp_q;
    logic             exp_vld_q;
    logic             err_q;

    // exp holds what the bank should show one edge after each RUN cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_q     <= '0;
            exp_vld_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            exp_vld_q <= in_run;
            if (in_run) begin
                exp_q <= target;
            end
            if (exp_vld_q && (q_fb != exp_q)) begin
                err_q <= 1'b1;
            end
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule
